// File: rtl/btn_conditioner.sv
// btn_conditioner: synchronizes, debounces and edge-detects the
// active-low push-buttons into active-high level/press/release/toggle.
module btn_conditioner #(
  parameter int WIDTH     = 5,
  parameter int DB_CYCLES = 1000000
) (
  input  logic             clk_50m,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] btn_n,
  input  logic             db_en,
  output logic [WIDTH-1:0] btn_state,
  output logic [WIDTH-1:0] btn_press,
  output logic [WIDTH-1:0] btn_release,
  output logic [WIDTH-1:0] btn_toggle
);

  localparam int CW = $clog2(DB_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DB_CYCLES - 1);

  typedef enum logic {
    STABLE,
    COUNTING
  } db_state_e;

  logic [WIDTH-1:0] s1;
  logic [WIDTH-1:0] s2;
  logic [WIDTH-1:0] raw;
  logic [WIDTH-1:0] lvl_d;
  logic [WIDTH-1:0] rise;
  logic [WIDTH-1:0] fall;

  db_state_e       st_q [WIDTH];
  db_state_e       st_d [WIDTH];
  logic [CW-1:0]   cnt_q [WIDTH];
  logic [CW-1:0]   cnt_d [WIDTH];

  assign raw  = ~s2;
  assign rise = lvl_d & ~btn_state;
  assign fall = ~lvl_d & btn_state;

  always_comb begin
    lvl_d = btn_state;
    for (int i = 0; i < WIDTH; i++) begin
      st_d[i]  = st_q[i];
      cnt_d[i] = cnt_q[i];
      unique case (1'b1)
        !db_en: begin
          st_d[i]  = STABLE;
          cnt_d[i] = '0;
          lvl_d[i] = raw[i];
        end
        db_en && (st_q[i] == STABLE): begin
          cnt_d[i] = '0;
          if (raw[i] != btn_state[i]) begin
            if (DB_CYCLES == 1) begin
              lvl_d[i] = raw[i];
            end else begin
              st_d[i]  = COUNTING;
              cnt_d[i] = CW'(1);
            end
          end
        end
        db_en && (st_q[i] == COUNTING): begin
          if (raw[i] == btn_state[i]) begin
            st_d[i]  = STABLE;
            cnt_d[i] = '0;
          end else if (cnt_q[i] == CNT_LAST) begin
            st_d[i]  = STABLE;
            cnt_d[i] = '0;
            lvl_d[i] = raw[i];
          end else begin
            cnt_d[i] = cnt_q[i] + CW'(1);
          end
        end
        default: begin
          st_d[i]  = STABLE;
          cnt_d[i] = '0;
        end
      endcase
    end
  end

  // Strobes derive from the next level so they land with it.
  always_ff @(posedge clk_50m) begin
    if (!rst_n) begin
      s1          <= '1;
      s2          <= '1;
      btn_state   <= '0;
      btn_press   <= '0;
      btn_release <= '0;
      btn_toggle  <= '0;
      for (int i = 0; i < WIDTH; i++) begin
        st_q[i]  <= STABLE;
        cnt_q[i] <= '0;
      end
    end else begin
      s1          <= btn_n;
      s2          <= s1;
      btn_state   <= lvl_d;
      btn_press   <= rise;
      btn_release <= fall;
      btn_toggle  <= btn_toggle ^ rise;
      for (int i = 0; i < WIDTH; i++) begin
        st_q[i]  <= st_d[i];
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

endmodule

// File: tb/tb_btn_conditioner.sv
// tb_btn_conditioner: directed vectors with hand-computed latencies
// for btn_conditioner at DB_CYCLES=4, WIDTH=5.
module tb_btn_conditioner;

  localparam int W = 5;

  logic         clk_50m;
  logic         rst_n;
  logic [W-1:0] btn_n;
  logic         db_en;
  logic [W-1:0] btn_state;
  logic [W-1:0] btn_press;
  logic [W-1:0] btn_release;
  logic [W-1:0] btn_toggle;

  int n_tot;
  int n_bad;

  int p_at  [W];
  int p_cnt [W];
  int r_at  [W];
  int r_cnt [W];
  int hi_cnt[W];
  int both;

  btn_conditioner #(
    .WIDTH    (W),
    .DB_CYCLES(4)
  ) dut (
    .clk_50m    (clk_50m),
    .rst_n      (rst_n),
    .btn_n      (btn_n),
    .db_en      (db_en),
    .btn_state  (btn_state),
    .btn_press  (btn_press),
    .btn_release(btn_release),
    .btn_toggle (btn_toggle)
  );

  initial begin
    clk_50m = 1'b0;
    forever #10 clk_50m = ~clk_50m;
  end

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_tot++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Samples are numbered in cycles after the mask bits fall.
  task automatic pulse(input logic [W-1:0] mask,
                       input int len,
                       input int win,
                       input int rst_at,
                       input int dis_at,
                       input int dis_len);
    for (int i = 0; i < W; i++) begin
      p_at[i]   = -1;
      r_at[i]   = -1;
      p_cnt[i]  = 0;
      r_cnt[i]  = 0;
      hi_cnt[i] = 0;
    end
    both = 0;
    for (int s = 0; s < win; s++) begin
      btn_n = (s < len) ? ~mask : '1;
      rst_n = (s == rst_at) ? 1'b0 : 1'b1;
      if (dis_at >= 0)
        db_en = !(s >= dis_at && s < dis_at + dis_len);
      @(negedge clk_50m);
      for (int i = 0; i < W; i++) begin
        if (btn_press[i]) begin
          p_cnt[i]++;
          if (p_at[i] < 0) p_at[i] = s + 1;
        end
        if (btn_release[i]) begin
          r_cnt[i]++;
          if (r_at[i] < 0) r_at[i] = s + 1;
        end
        if (btn_state[i]) hi_cnt[i]++;
        if (btn_press[i] && btn_release[i]) both++;
      end
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    @(negedge clk_50m);
    @(negedge clk_50m);
    rst_n = 1'b1;
  endtask

  initial begin
    int sp;
    int sr;
    n_tot = 0;
    n_bad = 0;
    rst_n = 1'b0;
    db_en = 1'b1;
    btn_n = 5'b01111;
    @(negedge clk_50m);
    @(negedge clk_50m);
    chk("rst_state",   btn_state,   0);
    chk("rst_press",   btn_press,   0);
    chk("rst_release", btn_release, 0);
    chk("rst_toggle",  btn_toggle,  0);

    pulse(5'b00000, 0, 12, -1, -1, 0);
    sp = 0;
    sr = 0;
    for (int i = 0; i < W; i++) begin
      sp += p_cnt[i];
      sr += r_cnt[i];
    end
    chk("rst_no_press",   sp, 0);
    chk("rst_no_release", sr, 0);
    chk("rst_b4_state",   hi_cnt[4], 0);

    db_en = 1'b0;
    pulse(5'b00001, 5, 12, -1, -1, 0);
    chk("byp_press_at",  p_at[0], 3);
    chk("byp_press_cnt", p_cnt[0], 1);
    chk("byp_state_len", hi_cnt[0], 5);
    chk("byp_rel_at",    r_at[0], 8);
    chk("byp_rel_cnt",   r_cnt[0], 1);
    chk("byp_both",      both, 0);
    chk("byp_toggle",    btn_toggle, 5'b00001);

    db_en = 1'b1;
    pulse(5'b00010, 3, 12, -1, -1, 0);
    chk("glitch_state", hi_cnt[1], 0);
    chk("glitch_press", p_cnt[1], 0);
    chk("glitch_rel",   r_cnt[1], 0);

    pulse(5'b00010, 10, 20, -1, -1, 0);
    chk("valid_press_at",  p_at[1], 6);
    chk("valid_press_cnt", p_cnt[1], 1);
    chk("valid_state_len", hi_cnt[1], 10);
    chk("valid_rel_at",    r_at[1], 16);
    chk("valid_rel_cnt",   r_cnt[1], 1);
    chk("valid_toggle",    btn_toggle, 5'b00011);

    do_reset();
    pulse(5'b00101, 8, 18, -1, -1, 0);
    chk("sim1_p0_at",  p_at[0], 6);
    chk("sim1_p2_at",  p_at[2], 6);
    chk("sim1_toggle", btn_toggle, 5'b00101);
    pulse(5'b00101, 8, 18, -1, -1, 0);
    chk("sim2_p0_at",  p_at[0], 6);
    chk("sim2_p2_at",  p_at[2], 6);
    chk("sim2_p1_cnt", p_cnt[1], 0);
    chk("sim2_toggle", btn_toggle, 5'b00000);

    pulse(5'b01000, 14, 24, 4, -1, 0);
    chk("rabort_press_at",  p_at[3], 11);
    chk("rabort_press_cnt", p_cnt[3], 1);
    chk("rabort_rel_at",    r_at[3], 20);
    chk("rabort_toggle",    btn_toggle, 5'b01000);

    pulse(5'b00010, 10, 24, -1, 3, 2);
    chk("dabort_press_at",  p_at[1], 4);
    chk("dabort_press_cnt", p_cnt[1], 1);
    chk("dabort_state_len", hi_cnt[1], 12);
    chk("dabort_rel_at",    r_at[1], 16);
    chk("dabort_both",      both, 0);

    $display("test done: total=%0d bad=%0d", n_tot, n_bad);
    $finish;
  end

endmodule
